// File: rtl/fetch_pc_unit_pkg.sv
// Shared fetch-stage definitions: FSM encoding, halt opcode, bubble word,
// reset PC default and the J-type target helper.
package fetch_pc_unit_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_STEP   = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [5:0]  HALT_OP_DEF  = 6'b111111;
  localparam logic [31:0] NOP_WORD     = 32'h0000_0000;

  // J-type target: upper nibble of the J's own PC+4, 26-bit word index.
  function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                              input logic [31:0] instr);
    return {pc_plus4[31:28], instr[25:0], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_unit_if_id_reg.sv
// IF/ID pipeline register. Priority: hold > flush (bubble) > load.
module if_id_reg
  import fetch_pc_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_load,
  input  logic        i_flush,
  input  logic        i_hold,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc_plus4,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc_plus4,
  output logic        o_valid
);

  logic [31:0] r_instr;
  logic [31:0] r_pc_plus4;
  logic        r_valid;

  // Register update: reset clears to a bubble, hold freezes, flush injects a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr    <= NOP_WORD;
      r_pc_plus4 <= 32'h0;
      r_valid    <= 1'b0;
    end else if (i_hold) begin
      r_instr    <= r_instr;
      r_pc_plus4 <= r_pc_plus4;
      r_valid    <= r_valid;
    end else if (i_flush) begin
      r_instr    <= NOP_WORD;
      r_pc_plus4 <= 32'h0;
      r_valid    <= 1'b0;
    end else if (i_load) begin
      r_instr    <= i_instr;
      r_pc_plus4 <= i_pc_plus4;
      r_valid    <= 1'b1;
    end
  end

  assign o_instr    = r_instr;
  assign o_pc_plus4 = r_pc_plus4;
  assign o_valid    = r_valid;

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch stage: PC register, RUN/HALTED/STEP debug FSM, fetch counter,
// and the IF/ID register instance.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = fetch_pc_unit_pkg::RESET_PC_DEF,
  parameter logic [5:0]  HALT_OP  = fetch_pc_unit_pkg::HALT_OP_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        jump_sel,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic [31:0] instr_in,
  input  logic        resume,
  input  logic        step,
  output logic [31:0] pc_out,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        halted,
  output logic [31:0] fetch_count
);

  fetch_state_t r_state;
  fetch_state_t w_state_next;
  logic [31:0]  r_pc;
  logic [31:0]  w_pc_next;
  logic [31:0]  w_pc_plus4;
  logic [31:0]  r_fetch_count;
  logic         w_cnt_inc;
  logic         w_load;
  logic         w_flush;
  logic         w_hold;
  logic         w_is_halt;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_is_halt  = (instr_in[31:26] == HALT_OP);

  // Next-state / next-PC / IF/ID control. RUN and STEP share the fetch rules.
  // Any cycle that ends in HALTED keeps pc_out on the word it just latched
  // (HALT word or the single stepped word), so resume/step advance from there.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_hold       = 1'b0;
    w_flush      = 1'b0;
    w_load       = 1'b0;
    w_cnt_inc    = 1'b0;
    case (r_state)
      ST_HALTED: begin
        w_flush = 1'b1;
        if (resume) begin
          w_pc_next    = w_pc_plus4;
          w_state_next = ST_RUN;
        end else if (step) begin
          w_pc_next    = w_pc_plus4;
          w_state_next = ST_STEP;
        end
      end
      ST_RUN, ST_STEP: begin
        if (stall) begin
          w_hold = 1'b1;
        end else if (branch_taken) begin
          w_pc_next = branch_target;
          w_flush   = 1'b1;
        end else if (jump_sel) begin
          w_pc_next = jump_target(if_id_pc_plus4, if_id_instr);
          w_flush   = 1'b1;
        end else begin
          w_load    = 1'b1;
          w_cnt_inc = 1'b1;
          if (w_is_halt || (r_state == ST_STEP)) begin
            w_state_next = ST_HALTED;
          end else begin
            w_pc_next = w_pc_plus4;
          end
        end
      end
      default: begin
        w_state_next = ST_RUN;
        w_flush      = 1'b1;
      end
    endcase
  end

  // State, PC and fetch counter registers; reset overrides every input.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_RUN;
      r_pc          <= RESET_PC;
      r_fetch_count <= 32'h0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      if (w_cnt_inc) r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  if_id_reg u_if_id (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_flush    (w_flush),
    .i_hold     (w_hold),
    .i_instr    (instr_in),
    .i_pc_plus4 (w_pc_plus4),
    .o_instr    (if_id_instr),
    .o_pc_plus4 (if_id_pc_plus4),
    .o_valid    (if_id_valid)
  );

  assign pc_out      = r_pc;
  assign halted      = (r_state == ST_HALTED);
  assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed scenarios plus randomized traffic, every
// cycle compared against a behavioural model of the fetch rules.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        reset, stall, jump_sel, branch_taken, resume, step;
  logic [31:0] branch_target;
  logic [31:0] instr_in;
  logic [31:0] pc_out, if_id_instr, if_id_pc_plus4, fetch_count;
  logic        if_id_valid, halted;

  logic [31:0] mem [64];

  int n_chk = 0;
  int n_err = 0;

  // model state
  localparam int M_RUN = 0, M_HALT = 1, M_STEP = 2;
  logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
  logic        m_valid;
  int          m_mode;

  fetch_pc_unit dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .jump_sel       (jump_sel),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .instr_in       (instr_in),
    .resume         (resume),
    .step           (step),
    .pc_out         (pc_out),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_valid    (if_id_valid),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  always_comb instr_in = mem[pc_out[7:2]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock of the reference behaviour, from the current inputs.
  task automatic model_step();
    logic [31:0] w;
    if (reset) begin
      m_pc = 32'h0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_cnt = 0; m_mode = M_RUN;
    end else if (m_mode == M_HALT) begin
      m_instr = 0; m_pc4 = 0; m_valid = 0;
      if (resume)    begin m_pc = m_pc + 4; m_mode = M_RUN;  end
      else if (step) begin m_pc = m_pc + 4; m_mode = M_STEP; end
    end else if (stall) begin
      // everything frozen
    end else if (branch_taken) begin
      m_pc = branch_target; m_instr = 0; m_pc4 = 0; m_valid = 0;
    end else if (jump_sel) begin
      m_pc = {m_pc4[31:28], m_instr[25:0], 2'b00};
      m_instr = 0; m_pc4 = 0; m_valid = 0;
    end else begin
      w = mem[m_pc[7:2]];
      m_instr = w; m_pc4 = m_pc + 4; m_valid = 1; m_cnt = m_cnt + 1;
      if (w[31:26] == 6'b111111 || m_mode == M_STEP) m_mode = M_HALT;
      else m_pc = m_pc + 4;
    end
  endtask

  task automatic check_all();
    chk("pc_out", pc_out, m_pc);
    chk("if_id_instr", if_id_instr, m_instr);
    chk("if_id_pc_plus4", if_id_pc_plus4, m_pc4);
    chk("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_valid});
    chk("halted", {31'b0, halted}, {31'b0, m_mode == M_HALT});
    chk("fetch_count", fetch_count, m_cnt);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    reset = 0; stall = 0; jump_sel = 0; branch_taken = 0;
    resume = 0; step = 0; branch_target = 0;
  endtask

  task automatic do_reset();
    idle(); reset = 1; cycle(); reset = 0;
  endtask

  logic [31:0] saved_cnt;
  logic [31:0] w;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = {6'd0, i[25:0]} + 32'h0010_0000;
    idle(); reset = 1;
    m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_cnt = 0; m_mode = M_RUN;
    cycle(); cycle();
    chk("reset_pc", pc_out, 32'h0);
    chk("reset_valid", {31'b0, if_id_valid}, 32'h0);
    reset = 0;

    // free run 0,4,8,C -> pc 10
    for (int i = 0; i < 4; i++) cycle();
    chk("run_pc", pc_out, 32'h10);
    chk("run_pc4", if_id_pc_plus4, 32'h10);
    chk("run_cnt", fetch_count, 32'd4);

    // J at 0x1000_000C with index 0x40
    mem[3] = {6'b000010, 26'h40};
    branch_taken = 1; branch_target = 32'h1000_000C; cycle(); idle();
    cycle();
    chk("j_in_ifid_pc4", if_id_pc_plus4, 32'h1000_0010);
    jump_sel = 1; cycle(); idle();
    chk("jump_pc", pc_out, 32'h1000_0100);
    chk("jump_bubble", {31'b0, if_id_valid}, 32'h0);
    cycle();
    chk("after_jump_valid", {31'b0, if_id_valid}, 32'h1);

    // branch beats jump
    saved_cnt = fetch_count;
    branch_taken = 1; jump_sel = 1; branch_target = 32'h200; cycle(); idle();
    chk("bj_pc", pc_out, 32'h200);
    chk("bj_valid", {31'b0, if_id_valid}, 32'h0);
    chk("bj_cnt", fetch_count, saved_cnt);

    // stall at pc 8
    do_reset(); cycle(); cycle();
    chk("pre_stall_pc", pc_out, 32'h8);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_pc", pc_out, 32'h8);
      chk("stall_cnt", fetch_count, 32'd2);
    end
    stall = 0; cycle();
    chk("release_pc", pc_out, 32'hC);
    chk("release_instr", if_id_instr, mem[2]);

    // HALT at 0x14, single step, resume
    mem[5] = 32'hFC00_1234;
    do_reset();
    for (int i = 0; i < 5; i++) cycle();
    cycle();
    chk("halt_flag", {31'b0, halted}, 32'h1);
    chk("halt_pc", pc_out, 32'h14);
    chk("halt_word", if_id_instr, 32'hFC00_1234);
    stall = 1; branch_taken = 1; branch_target = 32'h300; jump_sel = 1;
    cycle(); idle();
    chk("halt_ignores_pc", pc_out, 32'h14);
    chk("halt_bubble", {31'b0, if_id_valid}, 32'h0);
    step = 1; cycle(); idle();
    chk("step_pc", pc_out, 32'h18);
    cycle();
    chk("step_fetch_valid", {31'b0, if_id_valid}, 32'h1);
    chk("step_fetch_pc4", if_id_pc_plus4, 32'h1C);
    chk("step_rehalt", {31'b0, halted}, 32'h1);
    chk("step_cnt", fetch_count, 32'd7);
    cycle();
    resume = 1; step = 1; cycle(); idle();
    chk("resume_pc", pc_out, 32'h1C);
    chk("resume_run", {31'b0, halted}, 32'h0);
    cycle();
    chk("resume_fetch_pc", pc_out, 32'h20);

    // reset in STEP and in HALTED
    mem[5] = 32'h0010_0005;
    mem[1] = 32'hFC00_0001;
    do_reset(); cycle(); cycle();
    step = 1; cycle(); idle();
    reset = 1; stall = 1; cycle(); idle();
    chk("rst_step_pc", pc_out, 32'h0);
    chk("rst_step_cnt", fetch_count, 32'h0);
    cycle(); cycle();
    chk("halt_again", {31'b0, halted}, 32'h1);
    reset = 1; resume = 1; cycle(); idle();
    chk("rst_halt_flag", {31'b0, halted}, 32'h0);
    chk("rst_halt_valid", {31'b0, if_id_valid}, 32'h0);
    mem[1] = 32'h0010_0001;

    // PC wraps modulo 2^32
    branch_taken = 1; branch_target = 32'hFFFF_FFFC; cycle(); idle();
    cycle();
    chk("wrap_pc", pc_out, 32'h0);
    chk("wrap_pc4", if_id_pc_plus4, 32'h0);

    // randomized traffic with sprinkled HALT words
    for (int i = 0; i < 64; i++) begin
      w = $urandom;
      if ($urandom_range(11) == 0) w[31:26] = 6'b111111;
      else if (w[31:26] == 6'b111111) w[31:26] = 6'b000010;
      mem[i] = w;
    end
    for (int i = 0; i < 2000; i++) begin
      reset         = ($urandom_range(249) == 0);
      stall         = ($urandom_range(7) == 0);
      branch_taken  = ($urandom_range(9) == 0);
      jump_sel      = ($urandom_range(7) == 0);
      resume        = ($urandom_range(5) == 0);
      step          = ($urandom_range(4) == 0);
      branch_target = {$urandom} & 32'hFFFF_FFFC;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
